mem_rsp: RTL and testbench

Responder-side memory block that serves the core's instruction-fetch (ROM) port and data (RAM) port: word-organised storage, asynchronous reads, byte-masked writes. It also decodes a small MMIO window containing a free-running 64-bit cycle timer and a buffered serial-output FIFO. It sits directly under the core in the SoC top and drives the `i_rom_rd_data` and `i_ram_rd_data` inputs of the core.

---
 rtl/mem_rsp.sv | 223 ++++++++++++++++++++++
 tb/tb_mem_rsp.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_rsp.sv
// mem_rsp: word storage with combinational reads and byte-masked writes serving the core's ROM and
// RAM ports. The MMIO window (timer + serial TX FIFO) is built only when MEM_RSP_MMIO_EN is defined.
module mem_rsp #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           MEM_DEPTH  = 4096,
    parameter logic [ADDR_WIDTH-1:0] MEM_BASE   = 32'h8000_0000,
    parameter logic [ADDR_WIDTH-1:0] MMIO_BASE  = 32'hA000_0000,
    parameter int unsigned           TXQ_DEPTH  = 16
) (
    input  logic                    i_sys_clk,
    input  logic                    i_sys_rst_n,
    input  logic                    i_rom_rd_en,
    input  logic [ADDR_WIDTH-1:0]   i_rom_rd_addr,
    output logic [DATA_WIDTH-1:0]   o_rom_rd_data,
    input  logic                    i_ram_rd_en,
    input  logic [ADDR_WIDTH-1:0]   i_ram_rd_addr,
    output logic [DATA_WIDTH-1:0]   o_ram_rd_data,
    input  logic                    i_ram_wr_en,
    input  logic [ADDR_WIDTH-1:0]   i_ram_wr_addr,
    input  logic [DATA_WIDTH-1:0]   i_ram_wr_data,
    input  logic [DATA_WIDTH/8-1:0] i_ram_wr_mask,
    output logic                    o_uart_valid,
    output logic [7:0]              o_uart_data,
    input  logic                    i_uart_ready,
    output logic                    o_mem_err
);

    localparam int unsigned           IDX_W     = $clog2(MEM_DEPTH);
    localparam int unsigned           NLANES    = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(4 * MEM_DEPTH);

    // Unsigned offset compare also rejects addresses below the base (they wrap high).
    function automatic logic mem_hit(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] off;
        off = addr - MEM_BASE;
        return off < MEM_BYTES;
    endfunction

    function automatic logic [IDX_W-1:0] mem_idx(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] off;
        off = addr - MEM_BASE;
        return off[IDX_W+1:2];
    endfunction

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic                  rom_mem_hit, rd_mem_hit, wr_mem_hit;
    logic                  rom_mmio_hit, rd_mmio_hit, wr_mmio_hit;
    logic [DATA_WIDTH-1:0] rom_mmio_data, rd_mmio_data;
    logic                  err_d, err_q;

    assign rom_mem_hit = mem_hit(i_rom_rd_addr);
    assign rd_mem_hit  = mem_hit(i_ram_rd_addr);
    assign wr_mem_hit  = mem_hit(i_ram_wr_addr);

    always_comb begin
        o_rom_rd_data = '0;
        if (i_rom_rd_en) begin
            if (rom_mem_hit) begin
                o_rom_rd_data = mem[mem_idx(i_rom_rd_addr)];
            end else if (rom_mmio_hit) begin
                o_rom_rd_data = rom_mmio_data;
            end
        end
    end

    always_comb begin
        o_ram_rd_data = '0;
        if (i_ram_rd_en) begin
            if (rd_mem_hit) begin
                o_ram_rd_data = mem[mem_idx(i_ram_rd_addr)];
            end else if (rd_mmio_hit) begin
                o_ram_rd_data = rd_mmio_data;
            end
        end
    end

    // Storage is deliberately not reset so contents survive a mid-run reset.
    always_ff @(posedge i_sys_clk) begin
        if (i_ram_wr_en && wr_mem_hit) begin
            for (int l = 0; l < NLANES; l++) begin
                if (i_ram_wr_mask[l]) begin
                    mem[mem_idx(i_ram_wr_addr)][8*l +: 8] <= i_ram_wr_data[8*l +: 8];
                end
            end
        end
    end

    always_comb begin
        err_d = (i_rom_rd_en && !rom_mem_hit && !rom_mmio_hit) ||
                (i_ram_rd_en && !rd_mem_hit && !rd_mmio_hit) ||
                (i_ram_wr_en && !wr_mem_hit && !wr_mmio_hit);
    end

    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign o_mem_err = err_q;

`ifdef MEM_RSP_MMIO_EN
    localparam int unsigned PTR_W       = $clog2(TXQ_DEPTH);
    localparam int unsigned CNT_W       = PTR_W + 1;
    localparam logic [9:0]  REG_TIME_LO = 10'h012;
    localparam logic [9:0]  REG_TIME_HI = 10'h013;
    localparam logic [9:0]  REG_TX_DATA = 10'h0FE;
    localparam logic [9:0]  REG_TX_STAT = 10'h0FF;

    function automatic logic [9:0] mmio_reg(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] off;
        off = addr - MMIO_BASE;
        return off[11:2];
    endfunction

    function automatic logic mmio_dec(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] off;
        logic [9:0]            r;
        off = addr - MMIO_BASE;
        r   = off[11:2];
        return (off < ADDR_WIDTH'(4096)) &&
               (r inside {REG_TIME_LO, REG_TIME_HI, REG_TX_DATA, REG_TX_STAT});
    endfunction

    function automatic logic [DATA_WIDTH-1:0] mmio_rdata(input logic [9:0]  r,
                                                         input logic [63:0] timer,
                                                         input logic [31:0] shadow,
                                                         input logic        ovf,
                                                         input logic [4:0]  cnt);
        case (r)
            REG_TIME_LO: return DATA_WIDTH'(timer[31:0]);
            REG_TIME_HI: return DATA_WIDTH'(shadow);
            REG_TX_STAT: return DATA_WIDTH'({26'b0, ovf, cnt});
            default:     return '0;
        endcase
    endfunction

    logic [63:0]      timer_q;
    logic [31:0]      time_hi_shadow_q;
    logic [7:0]       fifo_q [TXQ_DEPTH];
    logic [PTR_W-1:0] wptr_q, rptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             time_lo_rd, mmio_wr, push_req, stat_wr, full, push, pop, overflow;

    assign rom_mmio_hit  = mmio_dec(i_rom_rd_addr);
    assign rd_mmio_hit   = mmio_dec(i_ram_rd_addr);
    assign wr_mmio_hit   = mmio_dec(i_ram_wr_addr);
    assign rom_mmio_data = mmio_rdata(mmio_reg(i_rom_rd_addr), timer_q, time_hi_shadow_q, ovf_q,
                                      5'(count_q));
    assign rd_mmio_data  = mmio_rdata(mmio_reg(i_ram_rd_addr), timer_q, time_hi_shadow_q, ovf_q,
                                      5'(count_q));

    always_comb begin
        time_lo_rd = (i_rom_rd_en && rom_mmio_hit && mmio_reg(i_rom_rd_addr) == REG_TIME_LO) ||
                     (i_ram_rd_en && rd_mmio_hit && mmio_reg(i_ram_rd_addr) == REG_TIME_LO);
        mmio_wr    = i_ram_wr_en && wr_mmio_hit;
        push_req   = mmio_wr && mmio_reg(i_ram_wr_addr) == REG_TX_DATA && i_ram_wr_mask[0];
        stat_wr    = mmio_wr && mmio_reg(i_ram_wr_addr) == REG_TX_STAT;
        full       = count_q == CNT_W'(TXQ_DEPTH);
        pop        = (count_q != '0) && i_uart_ready;
        // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
        push       = push_req && (!full || pop);
        overflow   = push_req && full && !pop;
        count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
        ovf_d      = ovf_q;
        if (stat_wr) begin
            ovf_d = 1'b0;
        end else if (overflow) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            timer_q          <= '0;
            time_hi_shadow_q <= '0;
            wptr_q           <= '0;
            rptr_q           <= '0;
            count_q          <= '0;
            ovf_q            <= 1'b0;
        end else begin
            timer_q <= timer_q + 64'd1;
            if (time_lo_rd) begin
                time_hi_shadow_q <= timer_q[63:32];
            end
            if (push) begin
                wptr_q <= wptr_q + PTR_W'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PTR_W'(1);
            end
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge i_sys_clk) begin
        if (push) begin
            fifo_q[wptr_q] <= i_ram_wr_data[7:0];
        end
    end

    assign o_uart_valid = count_q != '0;
    assign o_uart_data  = o_uart_valid ? fifo_q[rptr_q] : 8'h00;
`else
    logic unused_uart_ready;

    assign rom_mmio_hit      = 1'b0;
    assign rd_mmio_hit       = 1'b0;
    assign wr_mmio_hit       = 1'b0;
    assign rom_mmio_data     = '0;
    assign rd_mmio_data      = '0;
    assign o_uart_valid      = 1'b0;
    assign o_uart_data       = 8'h00;
    assign unused_uart_ready = i_uart_ready;
`endif

endmodule

// File: tb/tb_mem_rsp.sv
// tb_mem_rsp: directed + random checks of mem_rsp storage, error pulse and (if built) MMIO window
// against a word-array / byte-queue reference model.
module tb_mem_rsp;

    localparam logic [31:0] MEM_BASE  = 32'h8000_0000;
    localparam int          MEM_DEPTH = 4096;
    localparam logic [31:0] TIME_LO   = 32'hA000_0048;
    localparam logic [31:0] TIME_HI   = 32'hA000_004C;
    localparam logic [31:0] TX_DATA   = 32'hA000_03F8;
    localparam logic [31:0] TX_STAT   = 32'hA000_03FC;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rom_en, ram_rd_en, ram_wr_en, uart_ready;
    logic [31:0] rom_addr, rd_addr, wr_addr, wr_data, rom_data, rd_data;
    logic [3:0]  wr_mask;
    logic        uart_valid, mem_err;
    logic [7:0]  uart_data;

    int          errors = 0;
    int          checks = 0;
    logic [63:0] cyc;
    logic [31:0] model [int];
    logic [7:0]  txq [$];
    logic        m_ovf;

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= '0;
        else        cyc <= cyc + 64'd1;
    end

    mem_rsp dut (
        .i_sys_clk     (clk),
        .i_sys_rst_n   (rst_n),
        .i_rom_rd_en   (rom_en),
        .i_rom_rd_addr (rom_addr),
        .o_rom_rd_data (rom_data),
        .i_ram_rd_en   (ram_rd_en),
        .i_ram_rd_addr (rd_addr),
        .o_ram_rd_data (rd_data),
        .i_ram_wr_en   (ram_wr_en),
        .i_ram_wr_addr (wr_addr),
        .i_ram_wr_data (wr_data),
        .i_ram_wr_mask (wr_mask),
        .o_uart_valid  (uart_valid),
        .o_uart_data   (uart_data),
        .i_uart_ready  (uart_ready),
        .o_mem_err     (mem_err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rom_en = 0; ram_rd_en = 0; ram_wr_en = 0;
        rom_addr = 0; rd_addr = 0; wr_addr = 0; wr_data = 0; wr_mask = 0;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic logic in_mem(input logic [31:0] a);
        return a >= MEM_BASE && a < MEM_BASE + 32'(4 * MEM_DEPTH);
    endfunction

    // One-cycle write; the model follows the storage rules (undecoded and MMIO writes untouched).
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        int idx;
        ram_wr_en = 1; wr_addr = a; wr_data = d; wr_mask = m;
        tick();
        ram_wr_en = 0;
        if (in_mem(a)) begin
            idx = int'((a - MEM_BASE) >> 2);
            if (!model.exists(idx)) model[idx] = 32'hx;
            model[idx] = merge(model[idx], d, m);
        end
    endtask

    task automatic ram_read(input logic [31:0] a, output logic [31:0] d);
        ram_rd_en = 1; rd_addr = a;
        #1;
        d = rd_data;
    endtask

    task automatic err_pulse(input string tag);
        tick();
        idle();
        check({tag, "_err_hi"}, mem_err, 1);
        tick();
        check({tag, "_err_lo"}, mem_err, 0);
    endtask

    initial begin
        logic [31:0] d, last;
        logic [63:0] hi_exp;
        int          widx, ridx, oidx;
        rst_n = 0; uart_ready = 0; m_ovf = 0;
        idle();
        repeat (3) @(posedge clk);
        #1;
        check("rst_uart_valid", uart_valid, 0);
        check("rst_uart_data", uart_data, 0);
        check("rst_mem_err", mem_err, 0);
        check("rst_rom_data", rom_data, 0);
        check("rst_ram_data", rd_data, 0);
        rst_n = 1;
        tick();

        // Masked merge, read on both ports in one cycle.
        do_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF);
        do_write(32'h8000_0010, 32'h0000_00AA, 4'h1);
        rom_en = 1; rom_addr = 32'h8000_0010;
        ram_read(32'h8000_0010, d);
        check("merge_ram", d, 32'hDEAD_BEAA);
        check("merge_rom", rom_data, 32'hDEAD_BEAA);
        idle();

        // Read-during-write returns old contents.
        do_write(32'h8000_0020, 32'h0, 4'hF);
        ram_wr_en = 1; wr_addr = 32'h8000_0020; wr_data = 32'h1234_5678; wr_mask = 4'hF;
        ram_read(32'h8000_0020, d);
        check("rdw_old", d, 32'h0);
        tick();
        ram_wr_en = 0;
        #1;
        check("rdw_new", rd_data, 32'h1234_5678);
        model[8] = 32'h1234_5678;
        idle();

        // Random masked traffic over 16 words; address bits [1:0] randomised.
        for (int i = 0; i < 16; i++) do_write(MEM_BASE + 32'h100 + 32'(4 * i), $urandom, 4'hF);
        for (int i = 0; i < 60; i++) begin
            widx = $urandom_range(0, 15); ridx = $urandom_range(0, 15); oidx = $urandom_range(0, 15);
            ram_wr_en = 1'($urandom);
            ram_rd_en = 1'($urandom_range(0, 3) != 0);
            rom_en    = 1'($urandom_range(0, 3) != 0);
            wr_addr   = MEM_BASE + 32'h100 + 32'(4 * widx) + 32'($urandom_range(0, 3));
            rd_addr   = MEM_BASE + 32'h100 + 32'(4 * ridx) + 32'($urandom_range(0, 3));
            rom_addr  = MEM_BASE + 32'h100 + 32'(4 * oidx) + 32'($urandom_range(0, 3));
            wr_data   = $urandom;
            wr_mask   = 4'($urandom);
            #1;
            check("rand_ram", rd_data, ram_rd_en ? model[64 + ridx] : 32'h0);
            check("rand_rom", rom_data, rom_en ? model[64 + oidx] : 32'h0);
            tick();
            if (ram_wr_en) model[64 + widx] = merge(model[64 + widx], wr_data, wr_mask);
        end
        idle();

        // Storage boundaries and undecoded accesses.
        last = MEM_BASE + 32'(4 * (MEM_DEPTH - 1));
        do_write(last, 32'hCAFE_F00D, 4'hF);
        ram_read(last, d);
        check("last_word", d, 32'hCAFE_F00D);
        check("last_no_err", mem_err, 0);
        ram_read(MEM_BASE + 32'(4 * MEM_DEPTH), d);
        check("past_end_data", d, 0);
        err_pulse("past_end");
        ram_read(MEM_BASE - 32'd4, d);
        check("below_base_data", d, 0);
        err_pulse("below_base");
        ram_read(32'h0000_1000, d);
        check("undec_ram_data", d, 0);
        err_pulse("undec_ram");
        rom_en = 1; rom_addr = 32'h0000_1000;
        #1;
        check("undec_rom_data", rom_data, 0);
        err_pulse("undec_rom");
        do_write(32'h0000_1000, 32'hFFFF_FFFF, 4'hF);
        idle();
        check("undec_wr_err", mem_err, 1);
        tick();

`ifdef MEM_RSP_MMIO_EN
        // Timer: live low word, high word via shadow captured by the TIME_LO read.
        ram_read(TIME_LO, d);
        check("time_lo", d, cyc[31:0]);
        hi_exp = {32'h0, cyc[63:32]};
        tick();
        ram_read(TIME_HI, d);
        check("time_hi", d, hi_exp);
        idle();
        repeat (7) tick();
        do_write(TIME_LO, 32'h0, 4'hF);
        ram_read(TIME_LO, d);
        check("time_lo_later", d, cyc[31:0]);
        ram_read(TX_DATA, d);
        check("tx_data_rd", d, 0);
        idle();
        tick();
        check("mmio_no_err", mem_err, 0);

        // Overflow: 17 pushes with the sink stalled.
        for (int i = 0; i < 17; i++) begin
            do_write(TX_DATA, 32'(i), 4'h1);
            if (txq.size() < 16) txq.push_back(8'(i));
            else                 m_ovf = 1;
        end
        ram_read(TX_STAT, d);
        check("stat_ovf", d, {26'b0, m_ovf, 5'(txq.size())});
        idle();
        tick();
        check("stall_data", uart_data, txq[0]);
        uart_ready = 1;
        for (int i = 0; i < 16; i++) begin
            check("drain_valid", uart_valid, 1);
            check("drain_data", uart_data, txq.pop_front());
            tick();
        end
        check("drained_valid", uart_valid, 0);
        uart_ready = 0;
        do_write(TX_STAT, 32'h0, 4'h0);
        m_ovf = 0;
        ram_read(TX_STAT, d);
        check("stat_cleared", d, 0);
        idle();

        // Full FIFO with simultaneous pop and push: accepted, no overflow.
        for (int i = 0; i < 16; i++) begin
            do_write(TX_DATA, 32'h40 + 32'(i), 4'h1);
            txq.push_back(8'h40 + 8'(i));
        end
        uart_ready = 1;
        do_write(TX_DATA, 32'hEE, 4'h1);
        void'(txq.pop_front());
        txq.push_back(8'hEE);
        uart_ready = 0;
        ram_read(TX_STAT, d);
        check("full_pushpop_stat", d, {26'b0, m_ovf, 5'(txq.size())});
        idle();
        do_write(TX_DATA, 32'h77, 4'hE);
        uart_ready = 1;
        for (int i = 0; i < 16; i++) begin
            check("drain2_data", uart_data, txq.pop_front());
            tick();
        end
        check("drain2_empty", uart_valid, 0);
        uart_ready = 0;

        // Mid-run reset empties the FIFO at once; storage survives.
        for (int i = 0; i < 3; i++) do_write(TX_DATA, 32'h55, 4'h1);
        check("pre_rst_valid", uart_valid, 1);
        #2 rst_n = 0;
        #1;
        check("async_rst_valid", uart_valid, 0);
        check("async_rst_data", uart_data, 0);
        tick();
        rst_n = 1;
        ram_read(TX_STAT, d);
        check("post_rst_stat", d, 0);
`else
        // MMIO window absent: every access there is undecoded.
        do_write(TX_DATA, 32'h41, 4'h1);
        idle();
        check("nommio_wr_err", mem_err, 1);
        check("nommio_valid", uart_valid, 0);
        tick();
        check("nommio_err_lo", mem_err, 0);
        check("nommio_valid2", uart_valid, 0);
        ram_read(TIME_LO, d);
        check("nommio_time", d, 0);
        err_pulse("nommio_rd");
        #2 rst_n = 0;
        #1;
        check("async_rst_valid", uart_valid, 0);
        tick();
        rst_n = 1;
`endif
        ram_read(last, d);
        check("storage_retained", d, 32'hCAFE_F00D);
        ram_read(32'h8000_0010, d);
        check("storage_retained2", d, model[4]);
        idle();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
